ccw_output: RTL
===============

CCW_OUTPUT -- requirements
Module: ccw_output

Interface
REQ-001 Parameter: DATA_WIDTH, 64, flit width. Parameter: HOP_MSB, 55, hop-field high bit. Parameter: HOP_LSB, 48, hop-field low bit.
REQ-002 clk  in  1  clock, all state on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 polarity  in  1  global phase; 1 = odd VC on link / even VC internal, 0 = the reverse.
REQ-005 req_ccw_even, req_ccw_odd  in  1 each  requests from ccw input port, per VC.
REQ-006 req_pe_even, req_pe_odd  in  1 each  requests from pe input port, per VC.
REQ-007 din_ccw_even, din_ccw_odd, din_pe_even, din_pe_odd  in  DATA_WIDTH each  flit for matching request.
REQ-008 gnt_ccw_even, gnt_ccw_odd, gnt_pe_even, gnt_pe_odd  out  1 each  combinational grants.
REQ-009 ccwso  out  1  send strobe to downstream router, one cycle per flit.
REQ-010 ccwro  in  1  downstream ready; 1 = downstream can accept a flit this phase.
REQ-011 ccwdo  out  DATA_WIDTH  flit to downstream, valid when ccwso=1.

Function
REQ-012 Two single-entry buffers, even and odd, each with a full flag; empty after reset.
REQ-013 Internal VC = even when polarity=1, odd when polarity=0; only internal-VC buffer may be granted/filled.
REQ-014 Link VC = odd when polarity=1, even when polarity=0; only link-VC buffer may transmit.
REQ-015 Grant for VC v SHALL assert only if v is internal VC, buffer v empty, rst=0, and the source requests v.
REQ-016 Both sources requesting same VC: winner by per-VC round-robin pointer; exactly one grant asserted.
REQ-017 Round-robin pointer per VC: reset to ccw; after granting ccw it points to pe; after granting pe it points to ccw; unchanged when no grant.
REQ-018 At most one grant asserted per cycle across all four grant outputs.
REQ-019 On posedge with grant asserted: buffer v <= granted source's din, full_v <= 1 (zero-cycle grant, one-cycle capture).
REQ-020 Transmit condition: link-VC buffer full and ccwro=1 at posedge.
REQ-021 On transmit: ccwso <= 1, ccwdo <= buffer with [HOP_MSB:HOP_LSB] shifted right by 1 (zero fill), other bits unchanged; full flag cleared same edge.
REQ-022 No transmit: ccwso <= 0, ccwdo holds last value.
REQ-023 Link buffer full with ccwro=0: hold flit, no strobe; retry each cycle while polarity selects it.
REQ-024 Polarity toggles with buffer full: flit held, becomes non-grantable or non-transmittable per REQ-013/014; no data loss.
REQ-025 Fill and drain never target the same buffer in one cycle; throughput max one flit per cycle.
REQ-026 Grant deasserted when buffer full; requests held by source are not lost.

Reset
REQ-027 rst at posedge: both full flags 0, both RR pointers ccw, ccwso 0, ccwdo 0.
REQ-028 While rst=1 all grants 0, regardless of requests.
REQ-029 rst mid-operation discards buffered flits; no strobe in the reset cycle or the cycle after.

Structure
REQ-030 Shared package holds DATA_WIDTH, HOP_MSB, HOP_LSB, VC encoding (EVEN=0, ODD=1), source encoding (CCW=0, PE=1).
REQ-031 One sub-module ccw_out_vc: single-entry buffer plus 2-way RR arbiter, instantiated twice (even, odd); top holds polarity steering and link register.

Verification
REQ-032 polarity=1, req_ccw_even=1, din=64'h00F0_..._0001 -> gnt_ccw_even=1 same cycle; next polarity=0 with ccwro=1 -> ccwso=1, ccwdo[55:48]=8'h78, rest unchanged.
REQ-033 polarity=1, req_ccw_even and req_pe_even both 1 for 2 cycles; buffer drained between -> grants ccw then pe; reset pointer ccw.
REQ-034 polarity=0, odd buffer full, ccwro=0 for 3 cycles -> ccwso=0, odd buffer held; ccwro=1 -> one ccwso pulse, identical flit.
REQ-035 Even buffer full, polarity=1, req_pe_even=1 -> gnt_pe_even=0 until buffer drained during polarity=0.
REQ-036 Buffers full, rst=1 one cycle -> ccwso=0, ccwdo=0, grants 0; ccwro=1 afterward -> no transmit.
REQ-037 req_ccw_odd=1 while polarity=1 -> gnt_ccw_odd=0; polarity->0 -> gnt_ccw_odd=1 same cycle.

Source files
------------

// File: rtl/ccw_output_pkg.sv
// ccw_output_pkg: shared widths, hop-field bounds and VC/source encodings for the ccw output port
package ccw_output_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int HOP_MSB    = 55;
   localparam int HOP_LSB    = 48;
   typedef enum logic {VC_EVEN = 1'b0, VC_ODD = 1'b1} vc_e;
   typedef enum logic {SRC_CCW = 1'b0, SRC_PE = 1'b1} src_e;
endpackage

// File: rtl/ccw_output_if.sv
// ccw_output_if: request/grant/data bundle from the ccw and pe input ports plus the downstream link
//   polarity          : global phase (1 = odd VC on link, even VC internal)
//   req_*/din_*/gnt_* : per-source, per-VC request, flit and combinational grant
//   ccwso/ccwro/ccwdo : downstream strobe, ready and flit
interface ccw_output_if #(parameter int DATA_WIDTH = ccw_output_pkg::DATA_WIDTH);
   logic                  polarity;
   logic                  req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd;
   logic [DATA_WIDTH-1:0] din_ccw_even, din_ccw_odd, din_pe_even, din_pe_odd;
   logic                  gnt_ccw_even, gnt_ccw_odd, gnt_pe_even, gnt_pe_odd;
   logic                  ccwso, ccwro;
   logic [DATA_WIDTH-1:0] ccwdo;
   modport master (
      output polarity, req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd,
      output din_ccw_even, din_ccw_odd, din_pe_even, din_pe_odd, ccwro,
      input  gnt_ccw_even, gnt_ccw_odd, gnt_pe_even, gnt_pe_odd, ccwso, ccwdo
   );
   modport slave (
      input  polarity, req_ccw_even, req_ccw_odd, req_pe_even, req_pe_odd,
      input  din_ccw_even, din_ccw_odd, din_pe_even, din_pe_odd, ccwro,
      output gnt_ccw_even, gnt_ccw_odd, gnt_pe_even, gnt_pe_odd, ccwso, ccwdo
   );
endinterface

// File: rtl/ccw_out_vc.sv
// ccw_out_vc: single-entry flit buffer for one VC with a 2-way round-robin (ccw/pe) fill arbiter
//   en_i              : this VC is the internal (fillable) VC this phase
//   req_*_i/din_*_i   : source requests and flits; gnt_*_o combinational grants
//   drain_i           : link register is taking the buffered flit this edge
//   full_o/data_o     : buffer state toward the link side
module ccw_out_vc #(
   parameter int DATA_WIDTH = ccw_output_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  req_ccw_i,
   input  logic                  req_pe_i,
   input  logic [DATA_WIDTH-1:0] din_ccw_i,
   input  logic [DATA_WIDTH-1:0] din_pe_i,
   input  logic                  drain_i,
   output logic                  gnt_ccw_o,
   output logic                  gnt_pe_o,
   output logic                  full_o,
   output logic [DATA_WIDTH-1:0] data_o
);
   import ccw_output_pkg::*;
   src_e                  ptr_q, ptr_d;
   logic                  full_q, full_d, open;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   always_comb begin
      open      = en_i & ~full_q & ~rst;
      // the pointer only matters when both sources contend
      gnt_ccw_o = open & req_ccw_i & (~req_pe_i | ptr_q == SRC_CCW);
      gnt_pe_o  = open & req_pe_i & (~req_ccw_i | ptr_q == SRC_PE);
      ptr_d     = gnt_ccw_o ? SRC_PE : gnt_pe_o ? SRC_CCW : ptr_q;
      full_d    = (gnt_ccw_o | gnt_pe_o) ? 1'b1 : drain_i ? 1'b0 : full_q;
      data_d    = gnt_ccw_o ? din_ccw_i : gnt_pe_o ? din_pe_i : data_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= SRC_CCW;
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         full_q <= full_d;
         data_q <= data_d;
      end
   end
   assign full_o = full_q;
   assign data_o = data_q;
endmodule

// File: rtl/ccw_output.sv
// ccw_output: two-VC counter-clockwise output port; polarity steers fills to the internal VC and sends the link VC downstream
//   clk/rst : clock and synchronous active-high reset
//   bus     : ccw_output_if slave (requests, flits, grants, downstream strobe/ready/data)
module ccw_output #(
   parameter int DATA_WIDTH = ccw_output_pkg::DATA_WIDTH,
   parameter int HOP_MSB    = ccw_output_pkg::HOP_MSB,
   parameter int HOP_LSB    = ccw_output_pkg::HOP_LSB
) (
   input logic         clk,
   input logic         rst,
   ccw_output_if.slave bus
);
   import ccw_output_pkg::*;
   vc_e                   link_vc;
   logic                  full_v [2];
   logic [DATA_WIDTH-1:0] data_v [2];
   logic                  tx, ccwso_q, ccwso_d;
   logic [DATA_WIDTH-1:0] flit, ccwdo_q, ccwdo_d;
   ccw_out_vc #(.DATA_WIDTH(DATA_WIDTH)) u_even (
      .clk(clk), .rst(rst), .en_i(bus.polarity),
      .req_ccw_i(bus.req_ccw_even), .req_pe_i(bus.req_pe_even),
      .din_ccw_i(bus.din_ccw_even), .din_pe_i(bus.din_pe_even),
      .drain_i(tx & link_vc == VC_EVEN),
      .gnt_ccw_o(bus.gnt_ccw_even), .gnt_pe_o(bus.gnt_pe_even),
      .full_o(full_v[VC_EVEN]), .data_o(data_v[VC_EVEN])
   );
   ccw_out_vc #(.DATA_WIDTH(DATA_WIDTH)) u_odd (
      .clk(clk), .rst(rst), .en_i(~bus.polarity),
      .req_ccw_i(bus.req_ccw_odd), .req_pe_i(bus.req_pe_odd),
      .din_ccw_i(bus.din_ccw_odd), .din_pe_i(bus.din_pe_odd),
      .drain_i(tx & link_vc == VC_ODD),
      .gnt_ccw_o(bus.gnt_ccw_odd), .gnt_pe_o(bus.gnt_pe_odd),
      .full_o(full_v[VC_ODD]), .data_o(data_v[VC_ODD])
   );
   always_comb begin
      link_vc = bus.polarity ? VC_ODD : VC_EVEN;
      tx      = full_v[link_vc] & bus.ccwro & ~rst;
      // each hop consumed halves the hop field; everything else passes through
      flit    = data_v[link_vc];
      flit[HOP_MSB:HOP_LSB] = data_v[link_vc][HOP_MSB:HOP_LSB] >> 1;
      ccwso_d = tx;
      ccwdo_d = tx ? flit : ccwdo_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ccwso_q <= 1'b0;
         ccwdo_q <= '0;
      end else begin
         ccwso_q <= ccwso_d;
         ccwdo_q <= ccwdo_d;
      end
   end
   assign bus.ccwso = ccwso_q;
   assign bus.ccwdo = ccwdo_q;
endmodule
